pixel_unpacker: RTL and testbench
=================================

# pixel_unpacker

Parametrised pixel unpacker between the SRAM read-word path and the grayscale stage. It takes a stream of WORD_W-bit memory words, splits out PIX_W-bit pixels (packed or one-per-word padded), and assembles them into groups of GROUP pixels. Output uses a valid/ready handshake with backpressure, and a flush emits a final partial group. It generalises the fixed 32-bit/24-bit/4-pixel unpacker to arbitrary widths and group sizes.

## Interface
- WORD_W, 32, input word width; multiple of 8, WORD_W >= PIX_W
- PIX_W, 24, pixel width; multiple of 8
- GROUP, 4, pixels per output group; >= 1
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- sof  in  1  start-of-frame pulse; captures mode, clears accumulator and group
- mode  in  1  0 = packed (pixels contiguous across words), 1 = padded (word[PIX_W-1:0] is one pixel, upper bits discarded)
- flush  in  1  end-of-frame pulse; drain and emit partial group
- in_valid  in  1  word available
- in_ready  out  1  unpacker accepts word this cycle
- in_word  in  WORD_W  memory word, MSB-first pixel order
- out_valid  out  1  group available
- out_ready  in  1  downstream accepts group
- out_pixels  out  GROUP x PIX_W  packed array; first-extracted pixel in index GROUP-1, descending
- out_count  out  $clog2(GROUP+1)  number of valid pixels in group (GROUP except on flush)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. sof -> RUN, latches mode into mode_q, clears acc and group.
- RUN: accepts words. flush -> DRAIN. sof restarts (clear acc/group, re-latch mode; a held out_valid group is not dropped).
- DRAIN: in_ready=0. Extracts remaining whole pixels. Residual bits < PIX_W are discarded. If slot count > 0, presents partial group (unfilled slots 0, out_count = slots), then goes to IDLE on handshake. With an empty group, goes straight to IDLE.
- Accumulator: acc register is 2*WORD_W bits; acc_cnt holds valid bits, MSB-aligned.
- Accept when in_valid && in_ready, with in_ready = (state==RUN) && acc_cnt <= WORD_W, a registered-state function with no combinational path from in_valid/out_ready.
- Packed mode appends all WORD_W bits. Padded mode appends in_word[PIX_W-1:0] only.
- Extract: when acc_cnt >= PIX_W and group not blocked, the top PIX_W bits go into the next slot (slot index counts GROUP-1 down to 0) and acc_cnt -= PIX_W. Append and extract may happen on the same edge.
- At most one extraction per cycle.
- Group full: out_valid=1, out_count=GROUP. Blocked while out_valid && !out_ready.
- On handshake, the group clears; an extraction on the same edge writes slot GROUP-1.
- mode changes outside sof are ignored.

## Timing
- Reset: state IDLE, acc/acc_cnt 0, out_pixels all 0, out_count 0, out_valid 0, in_ready 0, busy 0.
- Word accepted on edge N: its first pixel is extracted at the earliest on edge N+1.
- out_valid rises the cycle after the edge that fills slot 0.
- While out_valid && !out_ready, out_pixels/out_count are held stable.
- Packed 32/24/4 at full input/output rate: 3 words -> 1 group. Input stalls are dictated only by the in_ready rule.
- sof and flush in the same cycle: sof wins.
- Reset mid-operation: immediate return to reset values; the partial group is lost.

## Structure
- Shared pkg pixel_pkg: typedef enum {IDLE, RUN, DRAIN} unpack_state_t; typedef enum logic {PACKED, PADDED} unpack_mode_t.
- One sub-module: pix_bit_accum, holding the acc shift register, acc_cnt, and the append/extract ports. The FSM, slot counter and group register stay in pixel_unpacker.

## Test plan
- Packed defaults: sof, mode=0; words 0x11223344, 0x55667788, 0x99AABBCC -> one group, out_pixels[3..0]=0x112233, 0x445566, 0x778899, 0xAABBCC, out_count=4.
- Padded: sof, mode=1; words 0xFF010203, 0xEE040506, 0xDD070809, 0xCC0A0B0C -> out_pixels[3..0]=0x010203, 0x040506, 0x070809, 0x0A0B0C.
- Backpressure: out_ready=0 for 10 cycles with 6 packed words streaming -> first group held stable, in_ready falls once acc_cnt > 32, no word lost. Release -> second group correct.
- Flush partial: one packed word 0x11223344, then flush -> out_pixels[3]=0x112233, [2..0]=0, out_count=1. Low byte 0x44 discarded; then IDLE, busy=0.
- sof mid-group: 2 packed words, then sof, then the 3-word sequence from test 1 -> first group equals test 1, with no stale pixels.
- Reset mid-RUN: assert n_rst low during extraction -> all outputs at reset values asynchronously. in_ready stays 0 until the next sof.

Source files
------------

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared types and sizing helper for the pixel unpacking path.
package pixel_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} unpack_state_t;
    typedef enum logic {PACKED, PADDED} unpack_mode_t;

    function automatic int bits_for(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/pix_bit_accum.sv
// pix_bit_accum: MSB-aligned bit accumulator with same-edge append and fixed-width extract.
module pix_bit_accum
    import pixel_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int PIX_W = 24,
    localparam int CNT_W = bits_for(2 * WORD_W)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic              app,
    input  logic [WORD_W-1:0] app_word,
    input  logic [CNT_W-1:0]  app_len,
    input  logic              ext,
    output logic [PIX_W-1:0]  top,
    output logic [CNT_W-1:0]  cnt
);
    logic [2*WORD_W-1:0] acc;
    logic [2*WORD_W-1:0] acc_base;
    logic [CNT_W-1:0]    cnt_base;

    // Bits below cnt are always zero, so a new word can simply be OR-ed in after the extract shift.
    always_comb begin
        acc_base = clr ? '0 : ext ? acc << PIX_W : acc;
        cnt_base = clr ? '0 : ext ? cnt - CNT_W'(PIX_W) : cnt;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= acc_base | (app ? {app_word, {WORD_W{1'b0}}} >> cnt_base : '0);
            cnt <= cnt_base + (app ? app_len : '0);
        end
    end

    assign top = acc[2*WORD_W-1 -: PIX_W];
endmodule

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: splits memory words into PIX_W-bit pixels and emits them in groups of GROUP
// over a valid/ready output, with flush emitting a final partial group.
module pixel_unpacker
    import pixel_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int PIX_W = 24,
    parameter int GROUP = 4,
    localparam int CNT_W = bits_for(2 * WORD_W),
    localparam int GC_W = bits_for(GROUP)
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        sof,
    input  logic                        mode,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W-1:0]           in_word,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [GROUP-1:0][PIX_W-1:0] out_pixels,
    output logic [GC_W-1:0]             out_count,
    output logic                        busy
);
    unpack_state_t state, state_n;
    unpack_mode_t  mode_q, eff_mode;
    logic [GC_W-1:0]   filled, fill_base, slot;
    logic [CNT_W-1:0]  acc_cnt;
    logic [PIX_W-1:0]  acc_top;
    logic hs, app, ext, clr, go_idle, partial, gclr, fill_last;

    assign hs        = out_valid && out_ready;
    assign app       = in_valid && in_ready;
    assign eff_mode  = sof ? unpack_mode_t'(mode) : mode_q;
    assign go_idle   = state == DRAIN && acc_cnt < CNT_W'(PIX_W) && (out_valid ? out_ready : filled == '0);
    assign clr       = sof || go_idle;
    assign ext       = state != IDLE && !clr && acc_cnt >= CNT_W'(PIX_W) && !(out_valid && !out_ready);
    assign partial   = state == DRAIN && !sof && !out_valid && acc_cnt < CNT_W'(PIX_W) && filled != '0;
    // A group already on offer survives sof; only an unoffered, partially filled group is discarded.
    assign gclr      = hs || (sof && !out_valid);
    assign fill_base = gclr ? '0 : filled;
    assign slot      = GC_W'(GROUP - 1) - fill_base;
    assign fill_last = ext && fill_base == GC_W'(GROUP - 1);

    pix_bit_accum #(.WORD_W(WORD_W), .PIX_W(PIX_W)) u_accum (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr      (clr),
        .app      (app),
        .app_word (eff_mode == PADDED ? in_word << (WORD_W - PIX_W) : in_word),
        .app_len  (eff_mode == PADDED ? CNT_W'(PIX_W) : CNT_W'(WORD_W)),
        .ext      (ext),
        .top      (acc_top),
        .cnt      (acc_cnt)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = sof ? RUN : (state == RUN && flush) ? DRAIN : go_idle ? IDLE : state;
    end

    always_comb begin
        in_ready = state == RUN && acc_cnt <= CNT_W'(WORD_W);
        busy     = state != IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q     <= PACKED;
            out_pixels <= '0;
            filled     <= '0;
            out_valid  <= 1'b0;
            out_count  <= '0;
        end else begin
            if (sof)
                mode_q <= unpack_mode_t'(mode);
            for (int i = 0; i < GROUP; i++)
                if (ext && slot == GC_W'(i))
                    out_pixels[i] <= acc_top;
                else if (gclr)
                    out_pixels[i] <= '0;
            filled    <= fill_base + GC_W'(ext);
            out_valid <= fill_last || partial || (out_valid && !out_ready);
            out_count <= fill_last ? GC_W'(GROUP) : partial ? filled : hs ? '0 : out_count;
        end
    end
endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker: directed and randomized checks of pixel_unpacker against a bit-stream model.
module tb_pixel_unpacker;
    localparam int W = 32, P = 24, G = 4;
    localparam logic [G*P-1:0] T1_GRP = 96'h112233_445566_778899_AABBCC;
    localparam logic [G*P-1:0] PAD_GRP = 96'h010203_040506_070809_0A0B0C;
    localparam logic [G*P-1:0] FL_GRP = 96'h112233_000000_000000_000000;

    logic clk = 0, n_rst = 1, sof = 0, mode = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0] in_word = '0;
    logic in_ready, out_valid, busy;
    logic [G-1:0][P-1:0] out_pixels;
    logic [2:0] out_count;

    typedef struct { logic [G*P-1:0] pix; int cnt; } grp_t;
    grp_t exp_q[$];
    logic [W-1:0] src_q[$];
    bit bits[$];
    logic [G*P-1:0] cur = '0, last_grp = '0, held_pix = '0;
    int checks = 0, errors = 0;
    int nfill = 0, last_cnt = 0, held_cnt = 0, valid_pct = 100, ready_pct = 100;
    bit model_mode = 0, was_blocked = 0, saw_stall = 0;

    always #5 clk = ~clk;

    pixel_unpacker dut (
        .clk(clk), .n_rst(n_rst), .sof(sof), .mode(mode), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixels(out_pixels),
        .out_count(out_count), .busy(busy)
    );

    task automatic check(input string tag, input logic [G*P-1:0] obs, input logic [G*P-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: pixels are successive P-bit chunks of the accepted bit stream, grouped G at a time.
    task automatic model_word(input logic [W-1:0] w);
        int n = model_mode ? P : W;
        for (int i = n - 1; i >= 0; i--) bits.push_back(w[i]);
        while (bits.size() >= P) begin
            logic [P-1:0] px;
            grp_t g;
            for (int i = P - 1; i >= 0; i--) px[i] = bits.pop_front();
            cur[(G-1-nfill)*P +: P] = px;
            nfill++;
            if (nfill == G) begin
                g.pix = cur;
                g.cnt = G;
                exp_q.push_back(g);
                cur = '0;
                nfill = 0;
            end
        end
    endtask

    task automatic model_sof(input bit m);
        bits.delete();
        cur = '0;
        nfill = 0;
        model_mode = m;
    endtask

    task automatic model_flush();
        grp_t g;
        bits.delete();
        if (nfill > 0) begin
            g.pix = cur;
            g.cnt = nfill;
            exp_q.push_back(g);
        end
        cur = '0;
        nfill = 0;
    endtask

    task automatic tick();
        if (!sof) mode = 1'($urandom_range(1));
        in_valid = src_q.size() > 0 && !sof && !flush && ($urandom_range(99) < valid_pct);
        in_word = src_q.size() > 0 ? src_q[0] : '0;
        out_ready = $urandom_range(99) < ready_pct;
        #4;
        if (was_blocked) begin
            check("held_valid", out_valid, 1);
            check("held_pix", out_pixels, held_pix);
            check("held_cnt", out_count, held_cnt);
        end
        if (out_valid && out_ready) begin
            last_grp = out_pixels;
            last_cnt = out_count;
            if (exp_q.size() == 0) check("extra_group", out_valid, 0);
            else begin
                grp_t e = exp_q.pop_front();
                check("grp_pix", out_pixels, e.pix);
                check("grp_cnt", out_count, e.cnt);
            end
        end
        if (busy && src_q.size() > 0 && !in_ready) saw_stall = 1;
        if (in_valid && in_ready) model_word(src_q.pop_front());
        if (sof) model_sof(mode);
        else if (flush) model_flush();
        was_blocked = out_valid && !out_ready;
        held_pix = out_pixels;
        held_cnt = out_count;
        @(negedge clk);
    endtask

    task automatic do_sof(input bit m);
        sof = 1;
        mode = m;
        tick();
        sof = 0;
    endtask

    task automatic do_flush();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic run_drain(input int budget);
        int n = budget;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n > 0) begin
            tick();
            n--;
        end
        check("drain_timeout", src_q.size() + exp_q.size(), 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = budget;
        while (busy && n > 0) begin
            tick();
            n--;
        end
        check("busy_end", busy, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cnt"}, out_count, 0);
        check({tag, "_pix"}, out_pixels, 0);
    endtask

    initial begin
        #1 n_rst = 0;
        #2 check_reset("rst");
        @(negedge clk);
        n_rst = 1;
        tick();
        check("idle_ready", in_ready, 0);

        do_sof(0);
        src_q = {32'h11223344, 32'h55667788, 32'h99AABBCC};
        run_drain(50);
        check("t1_pix", last_grp, T1_GRP);
        check("t1_cnt", last_cnt, 4);

        do_sof(1);
        src_q = {32'hFF010203, 32'hEE040506, 32'hDD070809, 32'hCC0A0B0C};
        run_drain(50);
        check("pad_pix", last_grp, PAD_GRP);
        check("pad_cnt", last_cnt, 4);

        do_sof(0);
        saw_stall = 0;
        ready_pct = 0;
        src_q = {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h11223344, 32'h55667788, 32'h99AABBCC};
        repeat (10) tick();
        check("bp_stall", saw_stall, 1);
        check("bp_valid", out_valid, 1);
        ready_pct = 100;
        run_drain(60);
        check("bp_pix", last_grp, T1_GRP);

        do_sof(0);
        src_q = {32'h11223344};
        run_drain(20);
        tick();
        do_flush();
        wait_idle(30);
        check("fl_pix", last_grp, FL_GRP);
        check("fl_cnt", last_cnt, 1);
        check("fl_ready", in_ready, 0);

        do_sof(0);
        src_q = {32'hDEADBEEF, 32'hCAFEF00D};
        run_drain(20);
        repeat (3) tick();
        last_grp = '0;
        do_sof(0);
        src_q = {32'h11223344, 32'h55667788, 32'h99AABBCC};
        run_drain(50);
        check("mid_pix", last_grp, T1_GRP);

        do_sof(0);
        src_q = {32'h11223344, 32'h55667788, 32'h99AABBCC};
        tick();
        tick();
        @(posedge clk);
        #2 n_rst = 0;
        #1 check_reset("arst");
        src_q.delete();
        exp_q.delete();
        model_sof(0);
        was_blocked = 0;
        @(negedge clk);
        n_rst = 1;
        repeat (3) begin
            tick();
            check("post_rst_ready", in_ready, 0);
        end

        valid_pct = 60;
        ready_pct = 60;
        for (int f = 0; f < 8; f++) begin
            int nw = $urandom_range(1, 12);
            do_sof(1'($urandom_range(1)));
            for (int k = 0; k < nw; k++) src_q.push_back($urandom);
            run_drain(400);
            do_flush();
            wait_idle(100);
            check("rnd_exp_left", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
